blowfish128_ffunc_arbiter: RTL and testbench

Shares one `blowfish128_ffunc` instance between up to NUM_REQ requesters, such as the 128-bit encrypt core and the P-array/S-box key-expansion engine. Requesters use the same Enable/X → Y/ready handshake that `blowfish128_ffunc` itself uses. The arbiter picks requesters round-robin, forwards the 64-bit X of the granted requester, and routes the returned Y back. It sits between the requesters and the single F-function instance at the blowfish128 top level.

---
 rtl/blowfish128_pkg.sv | 13 +
 rtl/blowfish128_rr_pick.sv | 29 ++
 rtl/blowfish128_ffunc_arbiter.sv | 134 +++++++++++++
 tb/tb_blowfish128_ffunc_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish128_pkg.sv
// Shared types and widths for the blowfish128 F-function handshake and its arbiter.
package blowfish128_pkg;

    localparam int FFUNC_W      = 64;
    localparam int FFUNC_HALF_W = FFUNC_W / 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ffunc_arb_state_t;

endpackage

// File: rtl/blowfish128_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant, wrapping.
module blowfish128_rr_pick
    import blowfish128_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic found;

    // Scan starts one past last_grant so the previous winner has lowest priority.
    always_comb begin
        valid = |req;
        index = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(last_grant) + k) % NUM_REQ]) begin
                index = IDX_W'((int'(last_grant) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blowfish128_ffunc_arbiter.sv
// Round-robin arbiter sharing one blowfish128_ffunc between NUM_REQ requesters.
// Optional watchdog compiled in with BLOWFISH128_ARB_TIMEOUT_EN.
module blowfish128_ffunc_arbiter
    import blowfish128_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                       Clk,
    input  logic                       RstN,
    input  logic [NUM_REQ-1:0]         req_enable,
    input  logic [NUM_REQ*FFUNC_W-1:0] req_X,
    output logic [FFUNC_W-1:0]         req_Y,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       timeout_err,
    output logic                       ffunc_enable,
    output logic [FFUNC_W-1:0]         ffunc_X,
    input  logic [FFUNC_W-1:0]         ffunc_Y,
    input  logic                       ffunc_ready
);

    ffunc_arb_state_t state, state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [FFUNC_W-1:0] x_reg;
    logic [FFUNC_W-1:0] y_reg;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               timed_out;

    blowfish128_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req       (req_enable),
        .last_grant(last_grant),
        .valid     (pick_valid),
        .index     (pick_idx)
    );

`ifdef BLOWFISH128_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_reg;

    // Counter restarts on every grant and only advances while the F-function is busy.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            to_cnt  <= '0;
            err_reg <= 1'b0;
        end else if (state == IDLE && pick_valid) begin
            to_cnt <= '0;
        end else if (state == BUSY) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (timed_out && !ffunc_ready)
                err_reg <= 1'b1;
        end
    end

    assign timed_out   = (state == BUSY) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign timeout_err = err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!RstN)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pick_valid) state_next = BUSY;
            BUSY: if (ffunc_ready || timed_out) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A real result takes precedence over a watchdog expiry in the same cycle.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant_id   <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        x_reg    <= req_X[int'(pick_idx)*FFUNC_W +: FFUNC_W];
                    end
                end
                BUSY: begin
                    if (ffunc_ready) begin
                        y_reg      <= ffunc_Y;
                        last_grant <= grant_id;
                    end else if (timed_out) begin
                        y_reg      <= '0;
                        last_grant <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    always_comb begin
        ffunc_enable = 1'b0;
        ffunc_X      = '0;
        req_ready    = '0;
        req_Y        = '0;
        case (state)
            BUSY: begin
                ffunc_enable = 1'b1;
                ffunc_X      = x_reg;
            end
            DONE: begin
                req_ready[grant_id] = 1'b1;
                req_Y               = y_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_blowfish128_ffunc_arbiter.sv
// Scoreboard bench for blowfish128_ffunc_arbiter with a behavioural F-function stub.
module tb_blowfish128_ffunc_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TO      = 16;

    logic           Clk = 1'b0;
    logic           RstN = 1'b0;
    logic [1:0]     req_enable;
    logic [127:0]   req_X;
    logic [63:0]    req_Y;
    logic [1:0]     req_ready;
    logic [0:0]     grant_id;
    logic           timeout_err;
    logic           ffunc_enable;
    logic [63:0]    ffunc_X;
    logic [63:0]    ffunc_Y;
    logic           ffunc_ready;

    blowfish128_ffunc_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk         (Clk),
        .RstN        (RstN),
        .req_enable  (req_enable),
        .req_X       (req_X),
        .req_Y       (req_Y),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .ffunc_enable(ffunc_enable),
        .ffunc_X     (ffunc_X),
        .ffunc_Y     (ffunc_Y),
        .ffunc_ready (ffunc_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic [63:0] y;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] xq0[$];
    logic [63:0] xq1[$];
    exp_t        sb[$];
    exp_t        e;
    int          readyCount0 = 0;
    int          readyCount1 = 0;
    int          gapCount = 0;
    bit          seenOp = 0;
    bit          prevEn = 0;
    bit          stubMute = 0;
    bit          stubActive = 0;
    bit          strayReq = 0;
    int          stubLat = 1;
    int          stubCnt = 0;

    function automatic logic [63:0] refY(input logic [63:0] x);
        return {x[31:0] ^ 32'h8e846390, x[63:32] ^ 32'h1df5be3b} + 64'h0123_4567_89ab_cdef;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic applyStimulus(input int r, input logic [63:0] x, input bit expectDone);
        if (r == 0) xq0.push_back(x);
        else        xq1.push_back(x);
        if (expectDone) sb.push_back('{r, refY(x)});
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        checkOutput({tag, "_drained"}, 64'(sb.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic startReset();
        RstN = 1'b0;
        tick();
        tick();
        xq0.delete();
        xq1.delete();
        sb.delete();
        readyCount0 = 0;
        readyCount1 = 0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ffunc_enable"}, 64'(ffunc_enable), 64'd0);
        checkOutput({tag, "_ffunc_X"},      ffunc_X,            64'd0);
        checkOutput({tag, "_req_ready"},    64'(req_ready),     64'd0);
        checkOutput({tag, "_req_Y"},        req_Y,              64'd0);
        checkOutput({tag, "_grant_id"},     64'(grant_id),      64'd0);
        checkOutput({tag, "_timeout_err"},  64'(timeout_err),   64'd0);
    endtask

    // Requester model plus scoreboard monitor; outputs sampled mid-cycle.
    always @(negedge Clk) begin
        if (RstN) begin
            if (req_ready != 2'b00) begin
                checkOutput("ready_onehot", 64'($countones(req_ready)), 64'd1);
                if (sb.size() == 0) begin
                    checkOutput("spurious_ready", 64'(req_ready), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ready_id", 64'(req_ready), 64'd1 << e.id);
                    checkOutput("grant_id", 64'(grant_id), 64'(e.id));
                    checkOutput("req_Y", req_Y, e.y);
                end
                if (req_ready[0]) begin
                    readyCount0++;
                    if (xq0.size() != 0) void'(xq0.pop_front());
                end
                if (req_ready[1]) begin
                    readyCount1++;
                    if (xq1.size() != 0) void'(xq1.pop_front());
                end
            end
            if (ffunc_enable) begin
                if (!prevEn && seenOp) checkOutput("enable_gap_ge2", 64'(gapCount >= 2), 64'd1);
                seenOp   = 1;
                gapCount = 0;
            end else begin
                gapCount++;
            end
            prevEn = ffunc_enable;
        end else begin
            seenOp   = 0;
            prevEn   = 0;
            gapCount = 0;
        end
        req_enable[0]  = (xq0.size() != 0);
        req_enable[1]  = (xq1.size() != 0);
        req_X[63:0]    = (xq0.size() != 0) ? xq0[0] : 64'd0;
        req_X[127:64]  = (xq1.size() != 0) ? xq1[0] : 64'd0;
    end

    // Behavioural F-function: responds a few cycles after seeing Enable.
    always @(negedge Clk) begin
        if (!RstN) begin
            ffunc_ready = 1'b0;
            stubActive  = 0;
        end else begin
            ffunc_ready = 1'b0;
            if (stubActive) begin
                if (stubCnt == 0) begin
                    ffunc_ready = 1'b1;
                    ffunc_Y     = refY(ffunc_X);
                    stubActive  = 0;
                end else begin
                    stubCnt--;
                end
            end else if (ffunc_enable && !stubMute) begin
                stubActive = 1;
                stubCnt    = stubLat + int'($urandom_range(0, 2));
            end
            if (strayReq) begin
                ffunc_ready = 1'b1;
                ffunc_Y     = 64'hdead_beef_0bad_f00d;
                strayReq    = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit anyReady;
        req_enable  = '0;
        req_X       = '0;
        ffunc_ready = 1'b0;
        ffunc_Y     = '0;

        startReset();
        checkResetValues("reset");
        RstN = 1'b1;
        tick();

        applyStimulus(0, 64'h1234_56ab_cd13_2536, 1);
        @(negedge Clk);
        tick();
        checkOutput("single_ffunc_enable", 64'(ffunc_enable), 64'd1);
        checkOutput("single_ffunc_X", ffunc_X, 64'h1234_56ab_cd13_2536);
        waitDrain("single");
        checkOutput("single_ready_count", 64'(readyCount0), 64'd1);

        startReset();
        applyStimulus(0, 64'h0f0f_1111_2222_3333, 1);
        applyStimulus(1, 64'hf0f0_4444_5555_6666, 1);
        RstN = 1'b1;
        waitDrain("simul");
        checkOutput("simul_count0", 64'(readyCount0), 64'd1);
        checkOutput("simul_count1", 64'(readyCount1), 64'd1);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 64'hA000_0000_0000_0000 + 64'(k), 1);
            applyStimulus(1, 64'hB000_0000_0000_0000 + 64'(k), 1);
        end
        waitDrain("fair");
        checkOutput("fair_count0", 64'(readyCount0), 64'd4);
        checkOutput("fair_count1", 64'(readyCount1), 64'd4);

        stubLat = 8;
        applyStimulus(1, 64'hC0DE_C0DE_C0DE_C0DE, 0);
        for (int i = 0; i < 20 && !ffunc_enable; i++) tick();
        checkOutput("midop_busy", 64'(ffunc_enable), 64'd1);
        RstN = 1'b0;
        tick();
        checkResetValues("midop_reset");
        xq0.delete();
        xq1.delete();
        sb.delete();
        applyStimulus(0, 64'h5555_aaaa_5555_aaaa, 1);
        applyStimulus(1, 64'h6666_bbbb_6666_bbbb, 1);
        stubLat = 1;
        RstN = 1'b1;
        waitDrain("post_reset");

        strayReq = 1;
        tick();
        tick();
        checkOutput("stray_enable", 64'(ffunc_enable), 64'd0);
        checkOutput("stray_ready", 64'(req_ready), 64'd0);
        checkOutput("stray_grant", 64'(grant_id), 64'd1);
        tick();
        checkOutput("stray_enable2", 64'(ffunc_enable), 64'd0);
        applyStimulus(0, 64'h7777_0000_7777_0000, 1);
        waitDrain("after_stray");

        stubMute = 1;
`ifdef BLOWFISH128_ARB_TIMEOUT_EN
        applyStimulus(0, 64'h9999_8888_7777_6666, 0);
        sb.push_back('{0, 64'd0});
`else
        applyStimulus(0, 64'h9999_8888_7777_6666, 0);
`endif
        for (int i = 0; i < 20 && !ffunc_enable; i++) tick();
        checkOutput("wd_busy", 64'(ffunc_enable), 64'd1);
`ifdef BLOWFISH128_ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) tick();
        checkOutput("wd_no_ready_early", 64'(req_ready), 64'd0);
        tick();
        checkOutput("wd_ready", 64'(req_ready), 64'd1);
        checkOutput("wd_req_Y", req_Y, 64'd0);
        checkOutput("wd_timeout_err", 64'(timeout_err), 64'd1);
        tick();
        tick();
        checkOutput("wd_timeout_sticky", 64'(timeout_err), 64'd1);
        waitDrain("wd");
`else
        anyReady = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (req_ready != 2'b00) anyReady = 1;
        end
        checkOutput("wd_no_ready", 64'(anyReady), 64'd0);
        checkOutput("wd_timeout_err", 64'(timeout_err), 64'd0);
        checkOutput("wd_still_busy", 64'(ffunc_enable), 64'd1);
`endif
        startReset();
        stubMute = 0;
        RstN = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
